cpu_fifo_bridge: RTL and testbench
==================================

// Module: cpu_fifo_bridge
// PURPOSE
//  Byte-wide register-mapped bridge between a simple CPU-style bus (sel/read/write/addr) and the USB_CDC byte streams.
//  OUT FIFO buffers host->device bytes from out_*; IN FIFO buffers device->host bytes to in_*.
//  Sits between the application controller and USB_CDC.
//  Raises per-FIFO event pulses so the controller can sleep between transfers.
// PARAMETERS
//  OUT_AW  2  log2 of OUT FIFO depth (depth = 2**OUT_AW, 2..7)
//  IN_AW   2  log2 of IN FIFO depth (depth = 2**IN_AW, 2..7)
// PORTS
//  clk_i        in   1  clock
//  rstn_i       in   1  asynchronous active-low reset
//  sel_i        in   1  bus select; read_i/write_i ignored when low
//  read_i       in   1  bus read strobe (one access per cycle)
//  write_i      in   1  bus write strobe; ignored if read_i is also high
//  addr_i       in   2  register address
//  data_i       in   8  write data
//  data_o       out  8  read data, registered
//  in_irq_o     out  1  1-cycle pulse: byte left IN FIFO via in_* handshake
//  out_irq_o    out  1  1-cycle pulse: byte entered OUT FIFO via out_* handshake
//  in_data_o    out  8  IN FIFO head byte
//  in_valid_o   out  1  IN FIFO not empty
//  in_ready_i   in   1  USB_CDC consumes in_data_o when in_valid_o & in_ready_i
//  out_data_i   in   8  byte from USB_CDC
//  out_valid_i  in   1  out_data_i valid; held until consumed
//  out_ready_o  out  1  OUT FIFO can accept; consumed when out_valid_i & out_ready_o
// BEHAVIOUR
//  Register map (access = sel_i & read_i, or sel_i & write_i & ~read_i):
//   00 R: ID 8'hC1.  W: bit0 = flush OUT FIFO, bit1 = flush IN FIFO, others ignored.
//   01 R: IN status. bit0 = not full, bit1 = empty, bit7 = sticky overflow (cleared by this read), rest 0.
//   01 W: push data_i into IN FIFO. If full: data dropped and overflow set.
//   10 R: OUT status. bit0 = not empty, bit1 = full, rest 0.
//   10 W: ignored.
//   11 R: pop OUT FIFO. data_o = head byte. If empty: data_o = 8'h00, no pop.
//   11 W: ignored.
//  Read latency: data_o updates on the clock edge ending the read cycle and holds until the next read.
//  Status reads report FIFO state AFTER that edge, including the same-cycle push/pop/flush.
//  This guarantees no event is lost when the controller clears its irq latch in the status-read cycle.
//  Each FIFO is circular: wr/rd pointers AW bits, count AW+1 bits, pointers wrap modulo depth.
//   Full when count == 2**AW; empty when count == 0.
//  in_valid_o and out_ready_o are registered from next-state count; in_data_o = mem[rd_ptr].
//  Simultaneous push+pop on one FIFO: both take effect, count unchanged, legal at full and at empty+push.
//  OUT FIFO:
//   - out_ready_o low when full.
//   - A pop on a full FIFO raises out_ready_o the next cycle (no same-cycle pass-through).
//  Flush: count and pointers are zeroed at that edge.
//   - It overrides a same-cycle push on that FIFO; the pushed byte is discarded.
//   - For OUT, a byte handshaken that cycle is consumed and lost, and out_irq_o is not pulsed.
//   - in_irq_o still pulses for a same-cycle IN pop.
//  irq pulses assert the cycle after the handshake edge, one pulse per byte, no coalescing.
//  Reset (async, rstn_i low): pointers, counts and overflow = 0; data_o = 8'h00; all irq outputs = 0.
//   in_valid_o = 0; out_ready_o = 0.
//   out_ready_o rises the first clock edge after release.
//   Reset mid-transfer discards all FIFO contents. Memory array need not be reset.
// TESTING
//  1. Reset release -> out_ready_o=1 after one edge, in_valid_o=0; read 00 -> 8'hC1; read 10 -> 8'h00; read 01 -> 8'h03.
//  2. USB pushes 'a','b' -> two out_irq_o pulses; read 10 -> 8'h01; read 11 twice -> 8'h61, 8'h62; read 11 again -> 8'h00, read 10 -> 8'h00.
//  3. Default depth: 5 writes to 01 with in_ready_i=0 -> in_valid_o=1, 5th byte dropped; read 01 -> 8'h80; re-read 01 -> 8'h00.
//  4. Fill OUT (4 bytes, out_ready_o->0, 5th held); pop one via 11 -> out_ready_o=1 next cycle, held byte accepted, order preserved.
//  5. Status read of 10 in the same cycle the first OUT byte is handshaken -> data_o = 8'h01.
//  6. Write 00 = 8'h03 while both FIFOs non-empty -> read 01 -> 8'h03, read 10 -> 8'h00, in_valid_o=0.
//  7. Assert rstn_i mid-stream -> outputs zero immediately, FIFOs empty after release.

Source files
------------

// File: rtl/cpu_fifo_bridge.sv
// cpu_fifo_bridge: byte-wide register-mapped bridge between a CPU-style
// sel/read/write bus and the USB_CDC byte streams. The OUT FIFO carries
// host->device bytes (out_* in, register 11 out). The IN FIFO carries
// device->host bytes (register 01 in, in_* out). Each FIFO has a one-cycle
// event pulse so the controller can sleep between transfers.
module cpu_fifo_bridge #(
  parameter int OUT_AW = 2,
  parameter int IN_AW  = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sel_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       in_irq_o,
  output logic       out_irq_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o
);

  localparam logic [7:0]      ID_VALUE   = 8'hC1;
  localparam logic [IN_AW:0]  IN_DEPTH   = {1'b1, {IN_AW{1'b0}}};
  localparam logic [OUT_AW:0] OUT_DEPTH  = {1'b1, {OUT_AW{1'b0}}};
  localparam logic [IN_AW:0]  IN_CNT_ONE  = 1;
  localparam logic [OUT_AW:0] OUT_CNT_ONE = 1;
  localparam logic [IN_AW-1:0]  IN_PTR_ONE  = 1;
  localparam logic [OUT_AW-1:0] OUT_PTR_ONE = 1;

  // ---------------------------------------------------------------------------
  // Bus decode. A read wins over a write in the same cycle.
  // ---------------------------------------------------------------------------
  logic acc_rd, acc_wr;
  assign acc_rd = sel_i & read_i;
  assign acc_wr = sel_i & write_i & ~read_i;

  logic flush_out, flush_in;
  assign flush_out = acc_wr && (addr_i == 2'b00) && data_i[0];
  assign flush_in  = acc_wr && (addr_i == 2'b00) && data_i[1];

  // ---------------------------------------------------------------------------
  // IN FIFO (bus writes -> in_* stream)
  // ---------------------------------------------------------------------------
  logic [7:0]       in_mem [2**IN_AW];
  logic [IN_AW-1:0] in_wr_ptr, in_rd_ptr;
  logic [IN_AW:0]   in_count, in_count_nxt;
  logic             in_ovf;
  logic             in_push_req, in_push, in_pop, in_full, in_ovf_set;

  assign in_full     = (in_count == IN_DEPTH);
  assign in_pop      = in_valid_o & in_ready_i;
  assign in_push_req = acc_wr && (addr_i == 2'b01);
  // A push into a full FIFO still succeeds when a pop frees a slot that edge.
  assign in_push     = in_push_req & (~in_full | in_pop);
  assign in_ovf_set  = in_push_req & in_full & ~in_pop;
  assign in_data_o   = in_mem[in_rd_ptr];

  // Next IN occupancy; flush wins over any same-cycle push or pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    in_count_nxt = in_count;
    if (flush_in)                in_count_nxt = '0;
    else if (in_push && !in_pop) in_count_nxt = in_count + IN_CNT_ONE;
    else if (!in_push && in_pop) in_count_nxt = in_count - IN_CNT_ONE;
  end

  // IN pointers, count, handshake flags, overflow and event pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rstn_i) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_count   <= '0;
      in_valid_o <= 1'b0;
      in_ovf     <= 1'b0;
      in_irq_o   <= 1'b0;
    end else begin
      in_count   <= in_count_nxt;
      in_valid_o <= (in_count_nxt != '0);
      in_irq_o   <= in_pop;
      if (flush_in) begin
        in_wr_ptr <= '0;
        in_rd_ptr <= '0;
      end else begin
        if (in_push) in_wr_ptr <= in_wr_ptr + IN_PTR_ONE;
        if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_PTR_ONE;
      end
      if (in_ovf_set)                         in_ovf <= 1'b1;
      else if (acc_rd && (addr_i == 2'b01))   in_ovf <= 1'b0;
    end
  end

  // IN storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately left out of reset; the
    // pointers and count define which entries are meaningful.
    if (in_push && !flush_in) in_mem[in_wr_ptr] <= data_i;
  end

  // ---------------------------------------------------------------------------
  // OUT FIFO (out_* stream -> bus reads of register 11)
  // ---------------------------------------------------------------------------
  logic [7:0]        out_mem [2**OUT_AW];
  logic [OUT_AW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OUT_AW:0]   out_count, out_count_nxt;
  logic              out_push, out_pop, out_not_empty;

  assign out_not_empty = (out_count != '0);
  // out_ready_o is low whenever the FIFO is full, so no push can overrun it.
  assign out_push      = out_valid_i & out_ready_o;
  assign out_pop       = acc_rd && (addr_i == 2'b11) && out_not_empty;

  // Next OUT occupancy; a flushed handshake is consumed and discarded.
  always_comb begin
    out_count_nxt = out_count;
    if (flush_out)                  out_count_nxt = '0;
    else if (out_push && !out_pop)  out_count_nxt = out_count + OUT_CNT_ONE;
    else if (!out_push && out_pop)  out_count_nxt = out_count - OUT_CNT_ONE;
  end

  // OUT pointers, count, ready flag and event pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_wr_ptr  <= '0;
      out_rd_ptr  <= '0;
      out_count   <= '0;
      out_ready_o <= 1'b0;
      out_irq_o   <= 1'b0;
    end else begin
      out_count   <= out_count_nxt;
      out_ready_o <= (out_count_nxt != OUT_DEPTH);
      out_irq_o   <= out_push & ~flush_out;
      if (flush_out) begin
        out_wr_ptr <= '0;
        out_rd_ptr <= '0;
      end else begin
        if (out_push) out_wr_ptr <= out_wr_ptr + OUT_PTR_ONE;
        if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_PTR_ONE;
      end
    end
  end

  // OUT storage write port.
  always_ff @(posedge clk_i) begin
    if (out_push && !flush_out) out_mem[out_wr_ptr] <= out_data_i;
  end

  // ---------------------------------------------------------------------------
  // Read data. Status reflects the post-edge FIFO state so an event arriving
  // in the status-read cycle is never hidden from the controller.
  // ---------------------------------------------------------------------------
  logic [7:0] rd_data;

  // Register read multiplexer.
  always_comb begin
    rd_data = 8'h00;
    unique case (addr_i)
      2'b00: rd_data = ID_VALUE;
      2'b01: rd_data = {in_ovf, 5'b0, (in_count_nxt == '0), (in_count_nxt != IN_DEPTH)};
      2'b10: rd_data = {6'b0, (out_count_nxt == OUT_DEPTH), (out_count_nxt != '0)};
      2'b11: rd_data = out_not_empty ? out_mem[out_rd_ptr] : 8'h00;
    endcase
  end

  // data_o captures on a read and holds until the next read.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     data_o <= 8'h00;
    else if (acc_rd) data_o <= rd_data;
  end

endmodule

// File: tb/tb_cpu_fifo_bridge.sv
// tb_cpu_fifo_bridge: scenario-driven bench for cpu_fifo_bridge with
// queue scoreboards for the OUT and IN byte streams.
module tb_cpu_fifo_bridge;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       sel_i = 1'b0, read_i = 1'b0, write_i = 1'b0;
  logic [1:0] addr_i = 2'b00;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       in_irq_o, out_irq_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] out_q[$];
  logic [7:0] in_q[$];

  cpu_fifo_bridge #(.OUT_AW(2), .IN_AW(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .sel_i(sel_i), .read_i(read_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .in_irq_o(in_irq_o), .out_irq_o(out_irq_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    sel_i = 1'b1; read_i = 1'b1; addr_i = a;
    tick();
    sel_i = 1'b0; read_i = 1'b0;
    d = data_o;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    sel_i = 1'b1; write_i = 1'b1; addr_i = a; data_i = v;
    tick();
    sel_i = 1'b0; write_i = 1'b0;
  endtask

  // Read register 11 and compare against the OUT scoreboard (00 when empty).
  task automatic pop_and_check(input string name);
    logic [7:0] d, exp;
    exp = (out_q.size() != 0) ? out_q.pop_front() : 8'h00;
    bus_read(2'b11, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: data_o got %h expected %h", name, d, exp);
    end
  endtask

  // USB side sends one byte; bounded wait for out_ready_o, then checks irq.
  task automatic usb_send(input logic [7:0] b, input string name);
    bit done = 0;
    out_valid_i = 1'b1; out_data_i = b;
    for (int i = 0; i < 50 && !done; i++) begin
      if (out_ready_o) done = 1;
      tick();
    end
    out_valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: out_ready_o never rose, got 0 expected 1", name);
    end else begin
      out_q.push_back(b);
      if (out_irq_o !== 1'b1) begin
        errors++;
        $display("FAIL %s_irq: out_irq_o got %b expected 1", name, out_irq_o);
      end
    end
  endtask

  // Drain IN FIFO via in_* and compare each byte against the IN scoreboard.
  task automatic drain_in(input string name);
    logic [7:0] exp;
    int n = 0;
    in_ready_i = 1'b1;
    while (in_valid_o && n < 20) begin
      exp = (in_q.size() != 0) ? in_q.pop_front() : 8'hxx;
      checks++;
      if (in_data_o !== exp) begin
        errors++;
        $display("FAIL %s_data: in_data_o got %h expected %h", name, in_data_o, exp);
      end
      tick();
      checks++;
      if (in_irq_o !== 1'b1) begin
        errors++;
        $display("FAIL %s_irq: in_irq_o got %b expected 1", name, in_irq_o);
      end
      n++;
    end
    in_ready_i = 1'b0;
    checks++;
    if (in_q.size() != 0) begin
      errors++;
      $display("FAIL %s_left: bytes left in model got %0d expected 0", name, in_q.size());
    end
  endtask

  task automatic expect_reg(input logic [1:0] a, input logic [7:0] exp, input string name);
    logic [7:0] d;
    bus_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: data_o got %h expected %h", name, d, exp);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    #12;
    checks++;
    if (out_ready_o !== 1'b0 || in_valid_o !== 1'b0 || data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ready/valid/data got %b/%b/%h expected 0/0/00",
               out_ready_o, in_valid_o, data_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    checks++;
    if (out_ready_o !== 1'b1 || in_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready/valid got %b/%b expected 1/0", out_ready_o, in_valid_o);
    end
    expect_reg(2'b00, 8'hC1, "read_id");
    expect_reg(2'b10, 8'h00, "out_status_reset");
    expect_reg(2'b01, 8'h03, "in_status_reset");
  endtask

  task automatic test_out_basic();
    usb_send(8'h61, "usb_a");
    usb_send(8'h62, "usb_b");
    expect_reg(2'b10, 8'h01, "out_status_two");
    pop_and_check("pop_a");
    pop_and_check("pop_b");
    pop_and_check("pop_empty");
    expect_reg(2'b10, 8'h00, "out_status_empty");
  endtask

  task automatic test_in_overflow();
    for (int i = 0; i < 5; i++) begin
      bus_write(2'b01, 8'h10 + 8'(i));
      if (i < 4) in_q.push_back(8'h10 + 8'(i));
    end
    checks++;
    if (in_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL in_valid_full: in_valid_o got %b expected 1", in_valid_o);
    end
    expect_reg(2'b01, 8'h80, "in_status_ovf");
    expect_reg(2'b01, 8'h00, "in_status_ovf_cleared");
    drain_in("in_drain");
    expect_reg(2'b01, 8'h03, "in_status_drained");
  endtask

  task automatic test_out_full_backpressure();
    for (int i = 0; i < 4; i++) usb_send(8'hA0 + 8'(i), "usb_fill");
    checks++;
    if (out_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL out_full_ready: out_ready_o got %b expected 0", out_ready_o);
    end
    expect_reg(2'b10, 8'h02 | 8'h01, "out_status_full");
    out_valid_i = 1'b1; out_data_i = 8'hA4;
    tick();
    checks++;
    if (out_ready_o !== 1'b0 || out_irq_o !== 1'b0) begin
      errors++;
      $display("FAIL out_held: ready/irq got %b/%b expected 0/0", out_ready_o, out_irq_o);
    end
    pop_and_check("pop_full_head");
    checks++;
    if (out_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL out_ready_after_pop: out_ready_o got %b expected 1", out_ready_o);
    end
    tick();
    out_valid_i = 1'b0;
    out_q.push_back(8'hA4);
    checks++;
    if (out_irq_o !== 1'b1 || out_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL out_held_accept: irq/ready got %b/%b expected 1/0", out_irq_o, out_ready_o);
    end
    for (int i = 0; i < 4; i++) pop_and_check("pop_order");
    pop_and_check("pop_after_order");
  endtask

  task automatic test_status_same_cycle();
    out_valid_i = 1'b1; out_data_i = 8'h5A;
    sel_i = 1'b1; read_i = 1'b1; addr_i = 2'b10;
    tick();
    sel_i = 1'b0; read_i = 1'b0; out_valid_i = 1'b0;
    out_q.push_back(8'h5A);
    checks++;
    if (data_o !== 8'h01 || out_irq_o !== 1'b1) begin
      errors++;
      $display("FAIL status_same_cycle: data/irq got %h/%b expected 01/1", data_o, out_irq_o);
    end
    pop_and_check("pop_same_cycle");
  endtask

  task automatic test_flush();
    bus_write(2'b01, 8'h11);
    bus_write(2'b01, 8'h22);
    usb_send(8'h33, "usb_pre_flush");
    usb_send(8'h44, "usb_pre_flush");
    bus_write(2'b00, 8'h03);
    out_q.delete();
    in_q.delete();
    expect_reg(2'b01, 8'h03, "in_status_flushed");
    expect_reg(2'b10, 8'h00, "out_status_flushed");
    checks++;
    if (in_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_valid: in_valid_o got %b expected 0", in_valid_o);
    end
    pop_and_check("pop_after_flush");
  endtask

  task automatic test_reset_midstream();
    usb_send(8'h77, "usb_pre_reset");
    usb_send(8'h78, "usb_pre_reset");
    pop_and_check("pop_pre_reset");
    bus_write(2'b01, 8'h99);
    out_valid_i = 1'b1; out_data_i = 8'h79;
    #2;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (data_o !== 8'h00 || out_ready_o !== 1'b0 || in_valid_o !== 1'b0 ||
        in_irq_o !== 1'b0 || out_irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: data/ready/valid/irqs got %h/%b/%b/%b%b expected 00/0/0/00",
               data_o, out_ready_o, in_valid_o, in_irq_o, out_irq_o);
    end
    out_valid_i = 1'b0;
    out_q.delete();
    in_q.delete();
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    expect_reg(2'b10, 8'h00, "out_status_after_reset");
    expect_reg(2'b01, 8'h03, "in_status_after_reset");
    pop_and_check("pop_after_reset");
  endtask

  initial begin
    test_reset();
    test_out_basic();
    test_in_overflow();
    test_out_full_backpressure();
    test_status_same_cycle();
    test_flush();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
